// File: rtl/alarma_ctrl.sv
// Alarm controller: arms/disarms, applies an entry delay, drives a time-limited
// siren and keeps a sticky "fired" flag. The alarm request is resynchronized to clk.
module alarma_ctrl #(
  parameter int unsigned RETARDO  = 4,
  parameter int unsigned DURACION = 6,
  parameter int unsigned CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       armar,
  input  logic       desarmar,
  input  logic       alarma_in,
  output logic       armado,
  output logic       sirena,
  output logic       disparo,
  output logic [2:0] estado
);

  typedef enum logic [2:0] {
    ST_DESARMADO = 3'd0,
    ST_ARMADO    = 3'd1,
    ST_RETARDO   = 3'd2,
    ST_SIRENA    = 3'd3,
    ST_BLOQUEO   = 3'd4
  } state_e;

  localparam logic [CNT_W-1:0] RET_LOAD = CNT_W'(RETARDO - 1);
  localparam logic [CNT_W-1:0] DUR_LOAD = CNT_W'(DURACION - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             disparo_q, disparo_d;
  logic             sync1_q, alarma_s_q;
  logic             sirena_q, armado_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    disparo_d = disparo_q;
    if (desarmar) begin
      state_d   = ST_DESARMADO;
      cnt_d     = '0;
      disparo_d = 1'b0;
    end else begin
      case (state_q)
        ST_DESARMADO: begin
          if (armar) state_d = ST_ARMADO;
        end
        ST_ARMADO: begin
          if (alarma_s_q) begin
            state_d = ST_RETARDO;
            cnt_d   = RET_LOAD;
          end
        end
        ST_RETARDO: begin
          // The entry delay runs to completion even if the request drops.
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_ONE;
          end else begin
            state_d   = ST_SIRENA;
            cnt_d     = DUR_LOAD;
            disparo_d = 1'b1;
          end
        end
        ST_SIRENA: begin
          if (cnt_q != '0) cnt_d = cnt_q - CNT_ONE;
          else             state_d = ST_BLOQUEO;
        end
        ST_BLOQUEO: begin
          if (alarma_s_q) begin
            state_d = ST_RETARDO;
            cnt_d   = RET_LOAD;
          end
        end
        default: begin
          state_d   = ST_DESARMADO;
          cnt_d     = '0;
          disparo_d = 1'b0;
        end
      endcase
    end
  end

  // Outputs are registered from the next-state value, so they track state_q exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_DESARMADO;
      cnt_q      <= '0;
      disparo_q  <= 1'b0;
      sync1_q    <= 1'b0;
      alarma_s_q <= 1'b0;
      sirena_q   <= 1'b0;
      armado_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      disparo_q  <= disparo_d;
      sync1_q    <= alarma_in;
      alarma_s_q <= sync1_q;
      sirena_q   <= (state_d == ST_SIRENA);
      armado_q   <= (state_d != ST_DESARMADO);
    end
  end

  assign armado  = armado_q;
  assign sirena  = sirena_q;
  assign disparo = disparo_q;
  assign estado  = state_q;

endmodule

// File: tb/tb_alarma_ctrl.sv
// Table-driven bench for alarma_ctrl with a scoreboard queue of expected outputs,
// plus hand-written sequences around asynchronous reset.
module tb_alarma_ctrl;

  logic       clk;
  logic       rst_n;
  logic       armar;
  logic       desarmar;
  logic       alarma_in;
  logic       armado;
  logic       sirena;
  logic       disparo;
  logic [2:0] estado;

  alarma_ctrl #(.RETARDO(4), .DURACION(6), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .armar     (armar),
    .desarmar  (desarmar),
    .alarma_in (alarma_in),
    .armado    (armado),
    .sirena    (sirena),
    .disparo   (disparo),
    .estado    (estado)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [2:0] S_DES = 3'd0;
  localparam logic [2:0] S_ARM = 3'd1;
  localparam logic [2:0] S_RET = 3'd2;
  localparam logic [2:0] S_SIR = 3'd3;
  localparam logic [2:0] S_BLQ = 3'd4;

  // exp packs {estado, sirena, disparo, armado}
  typedef struct packed {
    logic       armar;
    logic       desarmar;
    logic       alarma;
    logic [5:0] exp;
  } vec_t;

  vec_t       vecs[$];
  logic [5:0] sb[$];
  int         n_checks = 0;
  int         n_fail   = 0;

  task automatic add(input logic a, input logic d, input logic al,
                     input logic [2:0] e, input logic s, input logic di, input logic ar);
    vec_t v;
    v.armar    = a;
    v.desarmar = d;
    v.alarma   = al;
    v.exp      = {e, s, di, ar};
    vecs.push_back(v);
  endtask

  task automatic compare(input string name, input logic [5:0] exp);
    logic [5:0] got;
    got = {estado, sirena, disparo, armado};
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got estado=%0d sirena=%b disparo=%b armado=%b, required estado=%0d sirena=%b disparo=%b armado=%b",
               name, got[5:3], got[2], got[1], got[0], exp[5:3], exp[2], exp[1], exp[0]);
    end
  endtask

  // Drive on the falling edge, push the expectation, check after the rising edge.
  task automatic run_vec(input vec_t v, input string name);
    @(negedge clk);
    armar     = v.armar;
    desarmar  = v.desarmar;
    alarma_in = v.alarma;
    sb.push_back(v.exp);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: scoreboard empty, got estado=%0d required an entry", name, estado);
    end else begin
      compare(name, sb.pop_front());
    end
  endtask

  task automatic step(input logic a, input logic d, input logic al,
                      input logic [2:0] e, input logic s, input logic di, input logic ar,
                      input string name);
    vec_t v;
    v.armar    = a;
    v.desarmar = d;
    v.alarma   = al;
    v.exp      = {e, s, di, ar};
    run_vec(v, name);
  endtask

  initial begin
    rst_n     = 1'b0;
    armar     = 1'b0;
    desarmar  = 1'b0;
    alarma_in = 1'b0;

    // Arm, then idle: stays armed and quiet
    add(1, 0, 0, S_ARM, 0, 0, 1);
    for (int i = 0; i < 3; i++) add(0, 0, 0, S_ARM, 0, 0, 1);
    // One-cycle alarm pulse: RETARDO 3 edges later, 4 delay cycles, 6 siren cycles
    add(0, 0, 1, S_ARM, 0, 0, 1);
    add(0, 0, 0, S_ARM, 0, 0, 1);
    for (int i = 0; i < 4; i++) add(0, 0, 0, S_RET, 0, 0, 1);
    for (int i = 0; i < 6; i++) add(0, 0, 0, S_SIR, 1, 1, 1);
    add(0, 0, 0, S_BLQ, 0, 1, 1);
    add(0, 0, 0, S_BLQ, 0, 1, 1);
    // Retrigger from BLOQUEO keeps disparo and gives a second burst
    add(0, 0, 1, S_BLQ, 0, 1, 1);
    add(0, 0, 0, S_BLQ, 0, 1, 1);
    for (int i = 0; i < 4; i++) add(0, 0, 0, S_RET, 0, 1, 1);
    for (int i = 0; i < 6; i++) add(0, 0, 0, S_SIR, 1, 1, 1);
    add(0, 0, 0, S_BLQ, 0, 1, 1);
    add(0, 1, 0, S_DES, 0, 0, 0);
    // Disarmed with alarm held high: nothing happens
    for (int i = 0; i < 20; i++) add(0, 0, 1, S_DES, 0, 0, 0);
    add(1, 1, 1, S_DES, 0, 0, 0);
    add(0, 0, 0, S_DES, 0, 0, 0);
    add(0, 0, 0, S_DES, 0, 0, 0);
    // Armed, alarm high, disarm in the second delay cycle
    add(1, 0, 0, S_ARM, 0, 0, 1);
    add(0, 0, 1, S_ARM, 0, 0, 1);
    add(0, 0, 1, S_ARM, 0, 0, 1);
    add(0, 0, 1, S_RET, 0, 0, 1);
    add(0, 0, 1, S_RET, 0, 0, 1);
    add(0, 1, 1, S_DES, 0, 0, 0);
    for (int i = 0; i < 3; i++) add(0, 0, 0, S_DES, 0, 0, 0);
    // Disarm on the very edge the delay would expire
    add(1, 0, 0, S_ARM, 0, 0, 1);
    add(0, 0, 1, S_ARM, 0, 0, 1);
    add(0, 0, 0, S_ARM, 0, 0, 1);
    for (int i = 0; i < 4; i++) add(0, 0, 0, S_RET, 0, 0, 1);
    add(0, 1, 0, S_DES, 0, 0, 0);
    // Alarm held continuously: BLOQUEO lasts one cycle, then RETARDO again
    add(1, 0, 0, S_ARM, 0, 0, 1);
    add(0, 0, 1, S_ARM, 0, 0, 1);
    add(0, 0, 1, S_ARM, 0, 0, 1);
    for (int i = 0; i < 4; i++) add(0, 0, 1, S_RET, 0, 0, 1);
    for (int i = 0; i < 6; i++) add(0, 0, 1, S_SIR, 1, 1, 1);
    add(0, 0, 1, S_BLQ, 0, 1, 1);
    add(0, 0, 1, S_RET, 0, 1, 1);
    add(0, 1, 0, S_DES, 0, 0, 0);
    add(0, 0, 0, S_DES, 0, 0, 0);
    add(0, 0, 0, S_DES, 0, 0, 0);

    // Reset state, before any edge while rst_n is low
    #3;
    compare("reset_initial", {S_DES, 1'b0, 1'b0, 1'b0});
    repeat (2) @(posedge clk);
    #1;
    compare("reset_held", {S_DES, 1'b0, 1'b0, 1'b0});
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Asynchronous reset in the middle of the siren burst
    step(1, 0, 0, S_ARM, 0, 0, 1, "ar_arm");
    step(0, 0, 1, S_ARM, 0, 0, 1, "ar_pulse");
    step(0, 0, 0, S_ARM, 0, 0, 1, "ar_sync");
    for (int i = 0; i < 4; i++) step(0, 0, 0, S_RET, 0, 0, 1, $sformatf("ar_ret%0d", i));
    step(0, 0, 0, S_SIR, 1, 1, 1, "ar_sir0");
    step(0, 0, 0, S_SIR, 1, 1, 1, "ar_sir1");
    #2;
    rst_n     = 1'b0;
    alarma_in = 1'b1;
    #1;
    compare("async_reset_mid_sirena", {S_DES, 1'b0, 1'b0, 1'b0});
    repeat (3) @(posedge clk);
    #1;
    compare("reset_with_alarm_high", {S_DES, 1'b0, 1'b0, 1'b0});
    @(negedge clk);
    alarma_in = 1'b0;
    rst_n     = 1'b1;
    // Synchronizer and counter start clean after reset
    step(1, 0, 0, S_ARM, 0, 0, 1, "post_rst_arm");
    step(0, 0, 0, S_ARM, 0, 0, 1, "post_rst_idle0");
    step(0, 0, 0, S_ARM, 0, 0, 1, "post_rst_idle1");
    step(0, 0, 1, S_ARM, 0, 0, 1, "post_rst_pulse");
    step(0, 0, 0, S_ARM, 0, 0, 1, "post_rst_sync");
    for (int i = 0; i < 4; i++) step(0, 0, 0, S_RET, 0, 0, 1, $sformatf("post_rst_ret%0d", i));
    for (int i = 0; i < 6; i++) step(0, 0, 0, S_SIR, 1, 1, 1, $sformatf("post_rst_sir%0d", i));
    step(0, 0, 0, S_BLQ, 0, 1, 1, "post_rst_blq");
    step(0, 1, 0, S_DES, 0, 0, 0, "post_rst_disarm");

    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries left, required 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
